// File: rtl/ifetch_master_if.sv
// Bus bundle between the instruction-fetch master and its environment:
// the ROM read port on one side, and the decode handshake and redirect on the other.
interface ifetch_master_if;
    logic [63:0] HADDR;
    logic [63:0] HWDATA;
    logic        HWRITE;
    logic [63:0] HRDATA;
    logic        HREADY;

    logic        fetch_en;
    logic        redirect_valid;
    logic [63:0] redirect_pc;

    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [63:0] inst_pc;
    logic        fetch_fault;

    // The fetch unit's view of the bundle.
    modport master (
        output HADDR, HWDATA, HWRITE,
        input  HRDATA, HREADY,
        input  fetch_en, redirect_valid, redirect_pc,
        output inst_valid, inst_data, inst_pc, fetch_fault,
        input  inst_ready
    );

    // The view seen by the ROM, the decode stage and the redirect source.
    modport slave (
        input  HADDR, HWDATA, HWRITE,
        output HRDATA, HREADY,
        output fetch_en, redirect_valid, redirect_pc,
        input  inst_valid, inst_data, inst_pc, fetch_fault,
        output inst_ready
    );
endinterface

// File: rtl/ifetch_master.sv
// Instruction-fetch bus master: walks a sequential PC over a zero-wait ROM,
// buffers {instruction, PC} pairs in a small FIFO for decode, and accepts
// branch/trap redirects. A PC outside the legal window halts fetching.
module ifetch_master #(
    parameter logic [63:0] RESET_PC   = 64'h0,
    parameter logic [63:0] ROM_START  = 64'h0,
    parameter int          ROM_SIZE   = 256,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic            HCLK,
    input  logic            HRESETn,
    ifetch_master_if.master bus
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [63:0] WINDOW_LIMIT = 64'(ROM_SIZE) - 64'd4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        HOLD  = 2'd2,
        FAULT = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_stateNext;
    logic [63:0]        r_fetchPc;
    logic [63:0]        w_fetchPcNext;
    logic [CNT_W-1:0]   r_count;
    logic [PTR_W-1:0]   r_rdPtr;
    logic [PTR_W-1:0]   r_wrPtr;
    logic [31:0]        r_memData [FIFO_DEPTH];
    logic [63:0]        r_memPc   [FIFO_DEPTH];

    logic               w_redirect;
    logic               w_headValid;
    logic               w_popRaw;
    logic               w_pop;
    logic               w_push;
    logic               w_full;
    logic               w_space;
    logic [63:0]        w_pcOffset;
    logic               w_inWindow;
    logic               w_unusedBits;

    assign w_redirect  = bus.redirect_valid;
    assign w_headValid = (r_count != '0);
    assign w_full      = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_popRaw    = w_headValid & bus.inst_ready;
    // A redirect flushes the FIFO, so a pop in that same cycle has no effect.
    assign w_pop       = w_popRaw & ~w_redirect;
    assign w_space     = ~w_full | w_popRaw;

    // Offset subtraction makes a PC below ROM_START wrap to a huge value,
    // so a single unsigned compare covers both ends of the window.
    assign w_pcOffset  = r_fetchPc - ROM_START;
    assign w_inWindow  = (w_pcOffset < WINDOW_LIMIT);

    assign w_unusedBits = ^{bus.HRDATA[63:32], bus.redirect_pc[1:0]};

    assign bus.HADDR       = r_fetchPc;
    assign bus.HWDATA      = 64'h0;
    assign bus.HWRITE      = 1'b0;
    assign bus.inst_valid  = w_headValid;
    assign bus.inst_data   = w_headValid ? r_memData[r_rdPtr] : 32'h0;
    assign bus.inst_pc     = w_headValid ? r_memPc[r_rdPtr]   : 64'h0;
    assign bus.fetch_fault = (r_state == FAULT);

    // Next-state, next-PC and capture decision; a redirect overrides everything.
    always_comb begin
        w_stateNext   = r_state;
        w_fetchPcNext = r_fetchPc;
        w_push        = 1'b0;
        if (w_redirect) begin
            w_fetchPcNext = {bus.redirect_pc[63:2], 2'b00};
            w_stateNext   = bus.fetch_en ? RUN : IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.fetch_en) begin
                        w_stateNext = RUN;
                    end
                end
                RUN: begin
                    if (!bus.fetch_en) begin
                        w_stateNext = IDLE;
                    end else if (bus.HREADY) begin
                        if (!w_inWindow) begin
                            w_stateNext = FAULT;
                        end else if (w_space) begin
                            w_push        = 1'b1;
                            w_fetchPcNext = r_fetchPc + 64'd4;
                        end else begin
                            w_stateNext = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (w_popRaw) begin
                        w_stateNext = RUN;
                    end
                end
                FAULT: begin
                    w_stateNext = FAULT;
                end
                default: begin
                    w_stateNext = IDLE;
                end
            endcase
        end
    end

    // State and fetch PC registers.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            r_state   <= IDLE;
            r_fetchPc <= RESET_PC;
        end else begin
            r_state   <= w_stateNext;
            r_fetchPc <= w_fetchPcNext;
        end
    end

    // FIFO pointers and occupancy; reset and redirect both empty the buffer.
    always_ff @(posedge HCLK) begin
        if (!HRESETn || w_redirect) begin
            r_count <= '0;
            r_rdPtr <= '0;
            r_wrPtr <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO storage; stale contents are harmless because occupancy gates the head.
    always_ff @(posedge HCLK) begin
        if (w_push && HRESETn && !w_redirect) begin
            r_memData[r_wrPtr] <= bus.HRDATA[31:0];
            r_memPc[r_wrPtr]   <= r_fetchPc;
        end
    end

endmodule

// File: tb/tb_ifetch_master.sv
// Self-checking bench for ifetch_master against a zero-wait ROM model where
// word 0 is 0x00400093 and every other byte holds its own address.
module tb_ifetch_master;

    logic HCLK;
    logic HRESETn;

    ifetch_master_if bus ();

    ifetch_master #(
        .RESET_PC  (64'h0),
        .ROM_START (64'h0),
        .ROM_SIZE  (256),
        .FIFO_DEPTH(2)
    ) dut (
        .HCLK   (HCLK),
        .HRESETn(HRESETn),
        .bus    (bus)
    );

    int checkCount = 0;
    int failCount  = 0;

    // Free-running clock.
    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    function automatic logic [63:0] romWord(input logic [63:0] addr);
        logic [7:0] b0;
        if (addr == 64'h0) return 64'h0000_0000_0040_0093;
        b0 = addr[7:0];
        return {32'h0, b0 + 8'd3, b0 + 8'd2, b0 + 8'd1, b0};
    endfunction

    // Combinational ROM read port.
    assign bus.HRDATA = romWord(bus.HADDR);

    typedef struct {
        logic        rstn;
        logic        fe;
        logic        rdy;
        logic        hr;
        logic        rv;
        logic [63:0] rpc;
        logic        eValid;
        logic [63:0] ePc;
        logic [31:0] eData;
        logic [63:0] eHaddr;
        logic        eFault;
    } vec_t;

    localparam int NVEC = 25;
    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic rstn, input logic fe, input logic rdy,
                                input logic hr, input logic rv, input logic [63:0] rpc,
                                input logic eValid, input logic [63:0] ePc,
                                input logic [31:0] eData, input logic [63:0] eHaddr,
                                input logic eFault);
        vec_t v;
        v.rstn = rstn; v.fe = fe; v.rdy = rdy; v.hr = hr; v.rv = rv; v.rpc = rpc;
        v.eValid = eValid; v.ePc = ePc; v.eData = eData; v.eHaddr = eHaddr; v.eFault = eFault;
        return v;
    endfunction

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic applyStimulus(input logic rstn, input logic fe, input logic rdy,
                                 input logic hr, input logic rv, input logic [63:0] rpc);
        HRESETn            = rstn;
        bus.fetch_en       = fe;
        bus.inst_ready     = rdy;
        bus.HREADY         = hr;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkAll(input string tag, input logic eValid, input logic [63:0] ePc,
                            input logic [31:0] eData, input logic [63:0] eHaddr,
                            input logic eFault);
        checkOutput({tag, ".inst_valid"}, 64'(bus.inst_valid), 64'(eValid));
        checkOutput({tag, ".inst_pc"}, bus.inst_pc, ePc);
        checkOutput({tag, ".inst_data"}, 64'(bus.inst_data), 64'(eData));
        checkOutput({tag, ".HADDR"}, bus.HADDR, eHaddr);
        checkOutput({tag, ".fetch_fault"}, 64'(bus.fetch_fault), 64'(eFault));
        checkOutput({tag, ".HWRITE"}, 64'(bus.HWRITE), 64'h0);
        checkOutput({tag, ".HWDATA"}, bus.HWDATA, 64'h0);
    endtask

    // Main sequence: vector table, then hand-written window and HREADY sequences.
    initial begin
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 64'h0);

        // Sequential stream after reset
        vecs[0]  = mk(0,0,1,1,0,64'h0,  0,64'h0,  32'h0,        64'h0,  0);
        vecs[1]  = mk(1,1,1,1,0,64'h0,  0,64'h0,  32'h0,        64'h0,  0);
        vecs[2]  = mk(1,1,1,1,0,64'h0,  1,64'h0,  32'h00400093, 64'h4,  0);
        vecs[3]  = mk(1,1,1,1,0,64'h0,  1,64'h4,  32'h07060504, 64'h8,  0);
        vecs[4]  = mk(1,1,1,1,0,64'h0,  1,64'h8,  32'h0B0A0908, 64'hC,  0);
        // Backpressure from a fresh start
        vecs[5]  = mk(0,0,1,1,0,64'h0,  0,64'h0,  32'h0,        64'h0,  0);
        vecs[6]  = mk(1,1,0,1,0,64'h0,  0,64'h0,  32'h0,        64'h0,  0);
        vecs[7]  = mk(1,1,0,1,0,64'h0,  1,64'h0,  32'h00400093, 64'h4,  0);
        vecs[8]  = mk(1,1,0,1,0,64'h0,  1,64'h0,  32'h00400093, 64'h8,  0);
        vecs[9]  = mk(1,1,0,1,0,64'h0,  1,64'h0,  32'h00400093, 64'h8,  0);
        vecs[10] = mk(1,1,0,1,0,64'h0,  1,64'h0,  32'h00400093, 64'h8,  0);
        vecs[11] = mk(1,1,0,1,0,64'h0,  1,64'h0,  32'h00400093, 64'h8,  0);
        vecs[12] = mk(1,1,1,1,0,64'h0,  1,64'h4,  32'h07060504, 64'h8,  0);
        vecs[13] = mk(1,1,1,1,0,64'h0,  1,64'h8,  32'h0B0A0908, 64'hC,  0);
        vecs[14] = mk(1,1,1,1,0,64'h0,  1,64'hC,  32'h0F0E0D0C, 64'h10, 0);
        // Fill the FIFO, then redirect to an unaligned target
        vecs[15] = mk(0,0,1,1,0,64'h0,  0,64'h0,  32'h0,        64'h0,  0);
        vecs[16] = mk(1,1,0,1,0,64'h0,  0,64'h0,  32'h0,        64'h0,  0);
        vecs[17] = mk(1,1,0,1,0,64'h0,  1,64'h0,  32'h00400093, 64'h4,  0);
        vecs[18] = mk(1,1,0,1,0,64'h0,  1,64'h0,  32'h00400093, 64'h8,  0);
        vecs[19] = mk(1,1,1,1,1,64'h22, 0,64'h0,  32'h0,        64'h20, 0);
        vecs[20] = mk(1,1,1,1,0,64'h0,  1,64'h20, 32'h23222120, 64'h24, 0);
        vecs[21] = mk(1,1,1,1,0,64'h0,  1,64'h24, 32'h27262524, 64'h28, 0);
        // Two entries buffered, then a one-edge reset mid-stream
        vecs[22] = mk(1,1,0,1,0,64'h0,  1,64'h24, 32'h27262524, 64'h2C, 0);
        vecs[23] = mk(0,1,0,1,0,64'h0,  0,64'h0,  32'h0,        64'h0,  0);
        vecs[24] = mk(1,0,1,1,0,64'h0,  0,64'h0,  32'h0,        64'h0,  0);

        tick();
        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i].rstn, vecs[i].fe, vecs[i].rdy, vecs[i].hr,
                          vecs[i].rv, vecs[i].rpc);
            tick();
            checkAll($sformatf("vec%0d", i), vecs[i].eValid, vecs[i].ePc,
                     vecs[i].eData, vecs[i].eHaddr, vecs[i].eFault);
        end

        // Window end: 0xF8 is the last legal fetch, 0xFC faults
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 64'hF8);
        tick();
        checkAll("win.redir", 1'b0, 64'h0, 32'h0, 64'hF8, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 64'h0);
        tick();
        checkAll("win.f8", 1'b1, 64'hF8, 32'hFBFAF9F8, 64'hFC, 1'b0);
        tick();
        checkAll("win.fault", 1'b0, 64'h0, 32'h0, 64'hFC, 1'b1);
        tick();
        checkAll("win.faultHold", 1'b0, 64'h0, 32'h0, 64'hFC, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 64'h0);
        tick();
        checkAll("win.clear", 1'b0, 64'h0, 32'h0, 64'h0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 64'h0);
        tick();
        checkAll("win.restart", 1'b1, 64'h0, 32'h00400093, 64'h4, 1'b0);

        // HREADY low for three edges mid-stream: PC frozen, no pushes
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 64'h0);
        for (int k = 0; k < 3; k++) begin
            tick();
            checkAll($sformatf("hrdy.stall%0d", k), 1'b0, 64'h0, 32'h0, 64'h4, 1'b0);
        end
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 64'h0);
        tick();
        checkAll("hrdy.resume0", 1'b1, 64'h4, 32'h07060504, 64'h8, 1'b0);
        tick();
        checkAll("hrdy.resume1", 1'b1, 64'h8, 32'h0B0A0908, 64'hC, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
